// File: rtl/key_pkg.sv
// key_pkg: shared note codes, FSM state type and priority helpers for the key arbiter.
package key_pkg;
  localparam int NUM_KEYS = 7;
  typedef logic [3:0] note_t;
  localparam note_t NOTE_NONE = 4'd0;
  localparam note_t NOTE_DO   = 4'd1;
  localparam note_t NOTE_RE   = 4'd2;
  localparam note_t NOTE_MI   = 4'd3;
  localparam note_t NOTE_FA   = 4'd4;
  localparam note_t NOTE_SO   = 4'd5;
  localparam note_t NOTE_LA   = 4'd6;
  localparam note_t NOTE_TI   = 4'd7;
  localparam logic [2:0] IDX_NONE = 3'd7;
  typedef enum logic {IDLE, PLAYING} arb_state_t;
  function automatic logic [2:0] hi_idx(input logic [NUM_KEYS-1:0] v);
    hi_idx = IDX_NONE;
    for (int i = 0; i < NUM_KEYS; i++) if (v[i]) hi_idx = 3'(i);
  endfunction
  function automatic logic [2:0] lo_idx(input logic [NUM_KEYS-1:0] v);
    lo_idx = IDX_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) if (v[i]) lo_idx = 3'(i);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus stable-count debouncer for one key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s0, s1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0  <= 1'b0;
      s1  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s0 <= raw;
      s1 <= s0;
      // the cycle that brings the count to DEBOUNCE_CYCLES is the one that commits db
      if (s1 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= s1;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/key_note_arbiter.sv
// key_note_arbiter: debounces seven note keys, picks the last-pressed one and
// publishes note-on/off events through a single-entry valid/ready buffer.
module key_note_arbiter
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                clr_overrun,
  input  logic                ev_ready,
  output note_t               note_out,
  output logic                ev_valid,
  output note_t               ev_note,
  output logic                ev_on,
  output logic                overrun
);
  logic [NUM_KEYS-1:0] db, db_q, rise;
  logic [7:0] db_x;
  logic [2:0] act, act_nxt;
  arb_state_t state, state_nxt;
  note_t note_nxt, ev_note_nxt;
  logic ev_gen, ev_on_nxt;
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (key_raw[g]),
      .db   (db[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      act   <= IDX_NONE;
      db_q  <= '0;
    end else begin
      state <= state_nxt;
      act   <= act_nxt;
      db_q  <= db;
    end
  always_comb begin
    rise      = db & ~db_q;
    db_x      = {1'b0, db};
    act_nxt   = |rise ? hi_idx(rise) : (state == PLAYING && !db_x[act]) ? lo_idx(db) : act;
    state_nxt = (act_nxt == IDX_NONE) ? IDLE : PLAYING;
  end
  // an off-event reports the note being silenced; a switch only announces the new note
  always_comb begin
    note_nxt    = (state_nxt == PLAYING) ? note_t'({1'b0, act_nxt}) + 4'd1 : NOTE_NONE;
    ev_gen      = note_nxt != note_out;
    ev_on_nxt   = note_nxt != NOTE_NONE;
    ev_note_nxt = ev_on_nxt ? note_nxt : note_out;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      note_out <= NOTE_NONE;
      ev_valid <= 1'b0;
      ev_note  <= NOTE_NONE;
      ev_on    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      note_out <= note_nxt;
      overrun  <= (ev_gen & ev_valid & ~ev_ready) | (overrun & ~clr_overrun);
      if (ev_gen) begin
        ev_valid <= 1'b1;
        ev_note  <= ev_note_nxt;
        ev_on    <= ev_on_nxt;
      end else if (ev_ready) ev_valid <= 1'b0;
    end
endmodule

// File: tb/tb_key_note_arbiter.sv
// tb_key_note_arbiter: directed checks of debounce, arbitration and event handshake.
module tb_key_note_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] key_raw = '0;
  logic       clr_overrun = 1'b0;
  logic       ev_ready = 1'b1;
  logic [3:0] note_out, ev_note;
  logic       ev_valid, ev_on, overrun;
  int vectors = 0;
  int miscompares = 0;

  key_note_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .clr_overrun(clr_overrun),
    .ev_ready   (ev_ready),
    .note_out   (note_out),
    .ev_valid   (ev_valid),
    .ev_note    (ev_note),
    .ev_on      (ev_on),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_note(input string tag, input logic [3:0] exp, output int cyc);
    cyc = 0;
    while (note_out !== exp && cyc < 20) begin
      step();
      cyc++;
    end
    chk(tag, {4'd0, note_out}, {4'd0, exp});
  endtask

  task automatic chk_ev(input string tag, input logic [3:0] n, input logic on);
    chk({tag, "_valid"}, {7'd0, ev_valid}, 8'd1);
    chk({tag, "_note"}, {4'd0, ev_note}, {4'd0, n});
    chk({tag, "_on"}, {7'd0, ev_on}, {7'd0, on});
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      step();
      seen |= ev_valid | (note_out != 4'd0);
    end
    chk(tag, {7'd0, seen}, 8'd0);
  endtask

  initial begin
    int cyc;
    step(3);
    chk("rst_note", {4'd0, note_out}, 8'd0);
    chk("rst_valid", {7'd0, ev_valid}, 8'd0);
    chk("rst_evnote", {4'd0, ev_note}, 8'd0);
    chk("rst_on", {7'd0, ev_on}, 8'd0);
    chk("rst_ovr", {7'd0, overrun}, 8'd0);
    rst_n = 1'b1;
    quiet("post_rst_quiet", 4);
    // single press: 2 sync + 4 debounce + 1 register
    key_raw = 7'b0000100;
    wait_note("single_note", 4'd3, cyc);
    chk("single_latency_ok", {7'd0, (cyc >= 6 && cyc <= 8)}, 8'd1);
    chk_ev("single_on", 4'd3, 1'b1);
    step();
    chk("single_one_cycle", {7'd0, ev_valid}, 8'd0);
    key_raw = 7'b0;
    wait_note("single_rel", 4'd0, cyc);
    chk_ev("single_off", 4'd3, 1'b0);
    step();
    chk("single_off_one", {7'd0, ev_valid}, 8'd0);
    key_raw = 7'b0000001;
    step(3);
    key_raw = 7'b0;
    quiet("glitch", 12);
    key_raw = 7'b0000001;
    step(4);
    rst_n = 1'b0;
    key_raw = 7'b0;
    #1;
    rst_n = 1'b1;
    quiet("rst_midcount", 12);
    // reset with a pending event, asserted mid-cycle
    ev_ready = 1'b0;
    key_raw = 7'b0000010;
    wait_note("pend_note", 4'd2, cyc);
    chk("pend_valid", {7'd0, ev_valid}, 8'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_note", {4'd0, note_out}, 8'd0);
    chk("async_rst_valid", {7'd0, ev_valid}, 8'd0);
    key_raw = 7'b0;
    ev_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    quiet("async_rst_quiet", 10);
    key_raw = 7'b0000001;
    wait_note("lp_do", 4'd1, cyc);
    chk_ev("lp_do_ev", 4'd1, 1'b1);
    key_raw = 7'b0100001;
    wait_note("lp_la", 4'd6, cyc);
    chk_ev("lp_la_ev", 4'd6, 1'b1);
    key_raw = 7'b0000001;
    wait_note("lp_back", 4'd1, cyc);
    chk_ev("lp_back_ev", 4'd1, 1'b1);
    key_raw = 7'b0;
    wait_note("lp_off", 4'd0, cyc);
    chk_ev("lp_off_ev", 4'd1, 1'b0);
    step(2);
    key_raw = 7'b0010010;
    wait_note("simul", 4'd5, cyc);
    chk_ev("simul_ev", 4'd5, 1'b1);
    step();
    chk("simul_single", {7'd0, ev_valid}, 8'd0);
    chk("simul_hold", {4'd0, note_out}, 8'd5);
    key_raw = 7'b0;
    wait_note("simul_off", 4'd0, cyc);
    step(2);
    ev_ready = 1'b0;
    key_raw = 7'b0000001;
    wait_note("bp_do", 4'd1, cyc);
    chk_ev("bp_do_ev", 4'd1, 1'b1);
    chk("bp_no_ovr", {7'd0, overrun}, 8'd0);
    key_raw = 7'b0000101;
    wait_note("bp_mi", 4'd3, cyc);
    chk_ev("bp_mi_ev", 4'd3, 1'b1);
    chk("bp_ovr", {7'd0, overrun}, 8'd1);
    step(2);
    chk_ev("bp_stable", 4'd3, 1'b1);
    ev_ready = 1'b1;
    step();
    chk("bp_consumed", {7'd0, ev_valid}, 8'd0);
    chk("bp_ovr_sticky", {7'd0, overrun}, 8'd1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("bp_clr", {7'd0, overrun}, 8'd0);
    key_raw = 7'b0;
    wait_note("bp_end", 4'd0, cyc);
    chk_ev("bp_end_ev", 4'd3, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/key_note_arbiter.md
Name: key_note_arbiter

Overview:
- Sits between the seven raw note buttons and the note decode/tone path.
- Synchronises and debounces each key, then picks one active note when several keys are held, using a last-pressed-wins rule.
- Drives a registered 4-bit note code (0 = silence, 1..7 = do..ti).
- Issues note-on/note-off events to the tone scheduler over a valid/ready handshake.

Parameters:
- NUM_KEYS, 7: number of note keys. Fixed at 7 by the note encoding.
- DEBOUNCE_CYCLES, 20000: consecutive stable synchronised cycles required before a debounced key changes. Legal range is 1 or more.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_raw  input  7  raw button levels, asynchronous to clk. Bit i is note i+1.
- clr_overrun  input  1  single-cycle pulse that clears the overrun flag.
- ev_ready  input  1  consumer accepts the event this cycle.
- note_out  output  4  current active note, 0..7.
- ev_valid  output  1  event pending.
- ev_note  output  4  note the event refers to.
- ev_on  output  1  1 = note-on, 0 = note-off.
- overrun  output  1  sticky flag: a pending event was replaced before it was accepted.

Behaviour:
- Reset, asynchronous assert:
  - note_out=0, ev_valid=0, ev_note=0, ev_on=0, overrun=0.
  - Synchroniser flops, debounced vector db, db_q, counters, active index and FSM all clear.
- Reset takes effect at any point, including mid-debounce or with an event pending. A pending event is discarded.
- Synchroniser: 2 flops per key.
- Debounce, per key:
  - The counter increments while the synchronised value differs from db[i], and resets to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES, db[i] takes the synchronised value and the counter resets.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
- Arbitration is evaluated every cycle. Define rise = db & ~db_q.
  - Any rise bit set: the active key becomes the highest rising index. Simultaneous presses resolve to the highest note.
  - Otherwise, if the active key has db=0: the active key becomes the lowest index still set in db, or NONE if db is all zero.
  - Otherwise the active key is unchanged.
  - A release of a non-active key has no effect.
- FSM states:
  - IDLE (active=NONE) moves to PLAYING on any rise.
  - PLAYING moves to IDLE when the active key is released and no other key is held.
  - PLAYING to PLAYING is a note switch.
- note_out = active+1 in PLAYING, 0 in IDLE. It is registered one cycle after db changes.
- Latency from a stable key_raw edge to note_out: 2 + DEBOUNCE_CYCLES + 1 cycles, plus or minus 1 for synchroniser phase.
- Event generation: an event is generated whenever the next note_out differs from the current note_out.
  - New note nonzero: ev_note = new note, ev_on = 1.
  - New note 0: ev_note = previous note, ev_on = 0.
  - A note switch 3 to 5 produces a single on-event for 5. No off-event is generated for 3.
- Handshake (single-entry buffer):
  - ev_valid rises together with the note_out update.
  - ev_note and ev_on stay stable while ev_valid=1 and ev_ready=0.
  - The event is consumed on a cycle with ev_valid=1 and ev_ready=1.
  - If a new event arrives on the same cycle a consume occurs, ev_valid stays 1 with the new content and overrun is not set.
  - If a new event arrives while the pending event is unaccepted, the new event replaces it and overrun is set to 1.
- overrun is cleared by clr_overrun. If a set and a clear happen on the same cycle, set wins.
- ev_ready is ignored while ev_valid=0.

Decomposition:
- Shared package key_pkg holds:
  - NUM_KEYS=7.
  - note codes NOTE_NONE=0 and NOTE_DO..NOTE_TI=1..7.
  - a typedef note_t = logic [3:0].
  - the FSM state enum arb_state_t {IDLE, PLAYING}.
- One sub-module: key_debounce, containing the 2-flop synchroniser, the counter and db for a single key. It is instantiated NUM_KEYS times.

Test Plan (all with DEBOUNCE_CYCLES=4):
- Reset check: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Release with key_raw=0 -> outputs remain 0.
- Single press: hold key_raw=7'b0000100 with ev_ready=1 -> note_out=3 after 7±1 cycles. ev_valid=1 for exactly one cycle with ev_note=3, ev_on=1. Release -> note_out=0 and an event with ev_note=3, ev_on=0.
- Glitch rejection: pulse bit0 high for 3 cycles -> note_out stays 0 and no event. Then assert reset mid-count -> counters clear and no event.
- Last-pressed and fallback:
  - hold bit0 -> note 1.
  - add bit5 -> note 6.
  - release bit5 -> note 1, on-event.
  - release bit0 -> note 0, off-event with ev_note=1.
- Simultaneous press of bits 1 and 4 in the same cycle -> note_out=5, with one on-event for 5.
- Backpressure: ev_ready=0 and two note changes (1 then 3) -> ev_note=3, ev_on=1, overrun=1. Then ev_ready=1 -> consumed. Pulse clr_overrun -> overrun=0.
